// File: rtl/hazard_stall_ctrl.sv
// Load-use and MULT/DIV interlock for the ID stage, with a stall-cycle counter.
// Ports: clk, reset; ID/EXE hazard inputs; exc_flush; stall, md status, stall_count outputs.
module hazard_stall_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_use_hilo,
  input  logic        id_md_start,
  input  logic        exe_is_wb,
  input  logic [4:0]  exe_rd,
  input  logic [1:0]  exe_wdata_sel,
  input  logic        exc_flush,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_exe_bubble,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_count
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MD_LATENCY - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             load_haz;
  logic             md_haz;
  logic             stall;
  logic             rs_hit;
  logic             rt_hit;

  assign rs_hit = id_use_rs && (id_rs_addr == exe_rd);
  assign rt_hit = id_use_rt && (id_rt_addr == exe_rd);

  // A load in EXE has no data until MEM; $0 never carries a real value.
  assign load_haz = exe_is_wb && (exe_wdata_sel == 2'b00) &&
                    (exe_rd != 5'd0) && (rs_hit || rt_hit);

  assign md_haz = (state == MD_BUSY) && (id_use_hilo || id_md_start);

  assign stall = !reset && !exc_flush && (load_haz || md_haz);

  assign pc_stall      = stall;
  assign if_id_stall   = stall;
  assign id_exe_bubble = stall;
  assign md_busy       = (state == MD_BUSY);

  // cnt counts MD_LATENCY-1 down to 0 so busy spans exactly MD_LATENCY cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      cnt         <= '0;
      md_done     <= 1'b0;
      stall_count <= '0;
    end else begin
      md_done <= 1'b0;
      if (stall) begin
        stall_count <= stall_count + 32'd1;
      end
      if (exc_flush) begin
        state <= RUN;
        cnt   <= '0;
      end else begin
        unique case (1'b1)
          (state == RUN): begin
            if (id_md_start && !stall) begin
              state <= MD_BUSY;
              cnt   <= LAT_M1;
            end
          end
          (state == MD_BUSY): begin
            if (cnt == '0) begin
              state   <= RUN;
              md_done <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with MD_LATENCY=32.
// Hand-computed expectations, checked with immediate assertions.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_use_hilo;
  logic        id_md_start;
  logic        exe_is_wb;
  logic [4:0]  exe_rd;
  logic [1:0]  exe_wdata_sel;
  logic        exc_flush;
  logic        pc_stall;
  logic        if_id_stall;
  logic        id_exe_bubble;
  logic        md_busy;
  logic        md_done;
  logic [31:0] stall_count;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MD_LATENCY(32), .CNT_W(6)) dut (
    .clk(clk),
    .reset(reset),
    .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr),
    .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt),
    .id_use_hilo(id_use_hilo),
    .id_md_start(id_md_start),
    .exe_is_wb(exe_is_wb),
    .exe_rd(exe_rd),
    .exe_wdata_sel(exe_wdata_sel),
    .exc_flush(exc_flush),
    .pc_stall(pc_stall),
    .if_id_stall(if_id_stall),
    .id_exe_bubble(id_exe_bubble),
    .md_busy(md_busy),
    .md_done(md_done),
    .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    chk({tag, "_pc"}, {31'd0, pc_stall}, {31'd0, exp});
    chk({tag, "_ifid"}, {31'd0, if_id_stall}, {31'd0, exp});
    chk({tag, "_bub"}, {31'd0, id_exe_bubble}, {31'd0, exp});
  endtask

  // Advance to just after the next rising edge: start of the next cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs_addr    = 5'd0;
    id_rt_addr    = 5'd0;
    id_use_rs     = 1'b0;
    id_use_rt     = 1'b0;
    id_use_hilo   = 1'b0;
    id_md_start   = 1'b0;
    exe_is_wb     = 1'b0;
    exe_rd        = 5'd0;
    exe_wdata_sel = 2'b00;
    exc_flush     = 1'b0;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    // Load hazard present while in reset: outputs still 0.
    exe_is_wb  = 1'b1;
    exe_rd     = 5'd5;
    id_rs_addr = 5'd5;
    id_use_rs  = 1'b1;
    step();
    step();
    #1;
    chk_stall("rst_stall", 1'b0);
    chk("rst_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_done", {31'd0, md_done}, 32'd0);
    chk("rst_cnt", stall_count, 32'd0);

    reset = 1'b0;
    clr();
    step();

    // Load-use on rs.
    exe_is_wb  = 1'b1;
    exe_wdata_sel = 2'b00;
    exe_rd     = 5'd5;
    id_rs_addr = 5'd5;
    id_use_rs  = 1'b1;
    #1;
    chk_stall("lu_rs", 1'b1);
    step();
    exe_is_wb = 1'b0;
    #1;
    chk_stall("lu_after", 1'b0);
    chk("lu_cnt", stall_count, 32'd1);

    // ALU result (sel=01) forwards: no stall.
    exe_is_wb     = 1'b1;
    exe_wdata_sel = 2'b01;
    #1;
    chk_stall("alu_sel", 1'b0);

    // Load-use on rt.
    exe_wdata_sel = 2'b00;
    id_use_rs  = 1'b0;
    id_rs_addr = 5'd0;
    id_use_rt  = 1'b1;
    id_rt_addr = 5'd5;
    #1;
    chk_stall("lu_rt", 1'b1);
    step();
    clr();
    #1;
    chk("lu_rt_cnt", stall_count, 32'd2);

    // $0 destination never stalls.
    exe_is_wb  = 1'b1;
    exe_rd     = 5'd0;
    id_rs_addr = 5'd0;
    id_use_rs  = 1'b1;
    #1;
    chk_stall("zero_rd", 1'b0);
    // Address matches but rs not used.
    exe_rd     = 5'd5;
    id_rs_addr = 5'd5;
    id_use_rs  = 1'b0;
    #1;
    chk_stall("no_use", 1'b0);
    // Flush masks a real load hazard.
    id_use_rs = 1'b1;
    exc_flush = 1'b1;
    #1;
    chk_stall("flush_lu", 1'b0);
    step();
    clr();
    #1;
    chk("flush_lu_cnt", stall_count, 32'd2);

    // DIV issued at cycle t.
    id_md_start = 1'b1;
    #1;
    chk_stall("div_iss", 1'b0);
    chk("div_t_busy", {31'd0, md_busy}, 32'd0);
    step();
    id_md_start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      #1;
      chk("div_busy", {31'd0, md_busy}, 32'd1);
      chk("div_nodone", {31'd0, md_done}, 32'd0);
      step();
    end
    // mflo in ID from t+10 stalls through t+32.
    id_use_hilo = 1'b1;
    for (int k = 10; k <= 32; k++) begin
      #1;
      chk("mflo_busy", {31'd0, md_busy}, 32'd1);
      chk("mflo_stall", {31'd0, pc_stall}, 32'd1);
      step();
    end
    #1;
    chk("t33_done", {31'd0, md_done}, 32'd1);
    chk("t33_busy", {31'd0, md_busy}, 32'd0);
    chk_stall("t33_go", 1'b0);
    chk("t33_cnt", stall_count, 32'd25);
    step();
    id_use_hilo = 1'b0;
    #1;
    chk("t34_done", {31'd0, md_done}, 32'd0);
    chk("t34_cnt", stall_count, 32'd25);

    // MULT at s, DIV waits in ID from s+1 to s+32, issues at s+33.
    id_md_start = 1'b1;
    #1;
    chk_stall("mult_iss", 1'b0);
    step();
    for (int k = 1; k <= 32; k++) begin
      #1;
      chk("b2b_stall", {31'd0, pc_stall}, 32'd1);
      chk("b2b_busy", {31'd0, md_busy}, 32'd1);
      step();
    end
    #1;
    chk("b2b_done", {31'd0, md_done}, 32'd1);
    chk_stall("b2b_iss", 1'b0);
    chk("b2b_cnt", stall_count, 32'd57);
    step();
    // DIV issued at t'=s+33; now t'+1.
    id_md_start = 1'b0;
    id_use_hilo = 1'b1;
    #1;
    chk("b2b_rebusy", {31'd0, md_busy}, 32'd1);
    chk("b2b_redone", {31'd0, md_done}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("fl_pre_stall", {31'd0, pc_stall}, 32'd1);
      step();
    end
    // t'+5: flush.
    exc_flush = 1'b1;
    #1;
    chk_stall("fl_stall", 1'b0);
    chk("fl_busy_same", {31'd0, md_busy}, 32'd1);
    step();
    exc_flush = 1'b0;
    #1;
    chk("fl_busy_next", {31'd0, md_busy}, 32'd0);
    chk_stall("fl_mflo_go", 1'b0);
    chk("fl_cnt", stall_count, 32'd61);
    id_use_hilo = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      chk("fl_nodone", {31'd0, md_done}, 32'd0);
      step();
    end
    chk("fl_idle_busy", {31'd0, md_busy}, 32'd0);

    // Reset for one cycle during MD_BUSY.
    id_md_start = 1'b1;
    step();
    id_md_start = 1'b0;
    step();
    #1;
    chk("rb_busy", {31'd0, md_busy}, 32'd1);
    reset = 1'b1;
    id_use_hilo = 1'b1;
    #1;
    chk_stall("rb_in_rst", 1'b0);
    step();
    reset = 1'b0;
    id_use_hilo = 1'b0;
    #1;
    chk("rb_busy0", {31'd0, md_busy}, 32'd0);
    chk("rb_done0", {31'd0, md_done}, 32'd0);
    chk_stall("rb_stall0", 1'b0);
    chk("rb_cnt0", stall_count, 32'd0);
    for (int k = 0; k < 40; k++) begin
      #1;
      chk("rb_nodone", {31'd0, md_done}, 32'd0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
